// File: rtl/bloom_filter_loader.sv
// bloom_filter_loader: parses a host byte stream and drives the bloom-filter checker setup port.
// Build option LOADER_CKSUM_EN adds a trailing XOR checksum byte to LOAD and POKE.
//   state      | meaning
//   IDLE       | waiting for an opcode byte
//   GET_FILTER | waiting for the filter byte
//   SWEEP      | issuing one zero write per cycle
//   LOAD_BYTES | assembling and writing the 512 words of a filter
//   POKE_ADDR  | collecting the two address bytes
//   POKE_DATA  | collecting the four data bytes
//   CKSUM      | checking the trailing XOR byte (LOADER_CKSUM_EN only)
//   DONE       | command finished; done pulses on the following cycle
module bloom_filter_loader #(
    parameter int NUM_FILTERS = 16,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           wr_en,
    output logic                           zwr_en,
    output logic [DATA_W-1:0]              out_val,
    output logic [ADDR_W-1:0]              out_addr,
    output logic [$clog2(NUM_FILTERS)-1:0] filter_id,
    output logic                           busy,
    output logic                           done,
    output logic                           cmd_err
);

    localparam int FID_W = $clog2(NUM_FILTERS);
    localparam int BPW   = DATA_W / 8;

    localparam logic [7:0] OP_CLEAR_ALL = 8'h01;
    localparam logic [7:0] OP_CLEAR_ONE = 8'h02;
    localparam logic [7:0] OP_LOAD      = 8'h03;
    localparam logic [7:0] OP_POKE      = 8'h04;

    localparam logic [FID_W-1:0] LAST_FILT = FID_W'(NUM_FILTERS - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_FILTER,
        SWEEP,
        LOAD_BYTES,
        POKE_ADDR,
        POKE_DATA,
`ifdef LOADER_CKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;

`ifdef LOADER_CKSUM_EN
    localparam state_t POST_PAYLOAD = CKSUM;
    localparam logic   POST_READY   = 1'b1;
`else
    localparam state_t POST_PAYLOAD = DONE;
    localparam logic   POST_READY   = 1'b0;
`endif

    state_t              state;
    logic [7:0]          op;
    logic                filt_bad;
    logic                sweep_all;
    logic [1:0]          byte_cnt;
    logic [ADDR_W:0]     word_cnt;
    logic [DATA_W-9:0]   word_buf;

    logic                    accept;
    logic                    filt_bad_in;
    logic                    sweep_last;
    logic [ADDR_W:0]         word_next;
    logic [FID_W+ADDR_W-1:0] sweep_next;

    assign accept      = in_valid && in_ready;
    assign filt_bad_in = in_data >= 8'(NUM_FILTERS);
    assign word_next   = word_cnt + (ADDR_W+1)'(1);
    // filter_id/out_addr double as the sweep counter
    assign sweep_next  = {filter_id, out_addr} + (FID_W+ADDR_W)'(1);
    assign sweep_last  = (&out_addr) && (!sweep_all || filter_id == LAST_FILT);

`ifdef LOADER_CKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (accept && state == IDLE) begin
            csum <= '0;
        end else if (accept && state != CKSUM) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            filt_bad  <= 1'b0;
            sweep_all <= 1'b0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            word_buf  <= '0;
            in_ready  <= 1'b0;
            wr_en     <= 1'b0;
            zwr_en    <= 1'b0;
            out_val   <= '0;
            out_addr  <= '0;
            filter_id <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            zwr_en <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_data inside {OP_CLEAR_ALL, OP_CLEAR_ONE, OP_LOAD, OP_POKE}) begin
                            cmd_err  <= 1'b0;
                            busy     <= 1'b1;
                            op       <= in_data;
                            filt_bad <= 1'b0;
                            if (in_data == OP_CLEAR_ALL) begin
                                sweep_all <= 1'b1;
                                in_ready  <= 1'b0;
                                zwr_en    <= 1'b1;
                                filter_id <= '0;
                                out_addr  <= '0;
                                state     <= SWEEP;
                            end else begin
                                sweep_all <= 1'b0;
                                state     <= GET_FILTER;
                            end
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                GET_FILTER: begin
                    if (accept) begin
                        filter_id <= in_data[FID_W-1:0];
                        filt_bad  <= filt_bad_in;
                        byte_cnt  <= '0;
                        word_cnt  <= '0;
                        if (filt_bad_in) cmd_err <= 1'b1;
                        if (op == OP_CLEAR_ONE) begin
                            in_ready <= 1'b0;
                            if (filt_bad_in) begin
                                state <= DONE;
                            end else begin
                                zwr_en   <= 1'b1;
                                out_addr <= '0;
                                state    <= SWEEP;
                            end
                        end else if (op == OP_LOAD) begin
                            state <= LOAD_BYTES;
                        end else begin
                            state <= POKE_ADDR;
                        end
                    end
                end
                SWEEP: begin
                    if (sweep_last) begin
                        state <= DONE;
                    end else begin
                        zwr_en                <= 1'b1;
                        {filter_id, out_addr} <= sweep_next;
                    end
                end
                LOAD_BYTES: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {in_data, word_buf[DATA_W-9:8]};
                        if (byte_cnt == LAST_BYTE) begin
                            out_val  <= {in_data, word_buf};
                            out_addr <= word_cnt[ADDR_W-1:0];
                            wr_en    <= !filt_bad;
                            word_cnt <= word_next;
                            if (word_next[ADDR_W]) begin
                                in_ready <= POST_READY;
                                state    <= POST_PAYLOAD;
                            end
                        end
                    end
                end
                POKE_ADDR: begin
                    if (accept) begin
                        if (byte_cnt == 2'd0) begin
                            out_addr[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
                            byte_cnt             <= 2'd1;
                        end else begin
                            out_addr[7:0] <= in_data;
                            byte_cnt      <= 2'd0;
                            state         <= POKE_DATA;
                        end
                    end
                end
                POKE_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {in_data, word_buf[DATA_W-9:8]};
                        if (byte_cnt == LAST_BYTE) begin
                            out_val  <= {in_data, word_buf};
                            wr_en    <= !filt_bad;
                            in_ready <= POST_READY;
                            state    <= POST_PAYLOAD;
                        end
                    end
                end
`ifdef LOADER_CKSUM_EN
                CKSUM: begin
                    if (accept) begin
                        if (in_data != csum) cmd_err <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bloom_filter_loader.sv
// Bench for bloom_filter_loader: random and directed command streams checked against a
// write-list model built from the command bytes.
module tb_bloom_filter_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, zwr_en, busy, done, cmd_err;
    logic [31:0] out_val;
    logic [8:0]  out_addr;
    logic [3:0]  filter_id;

    bloom_filter_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .zwr_en(zwr_en), .out_val(out_val),
        .out_addr(out_addr), .filter_id(filter_id), .busy(busy), .done(done),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        z;
        logic [3:0]  f;
        logic [8:0]  a;
        logic [31:0] v;
        longint      cyc;
    } ev_t;

    ev_t    obs[$];
    ev_t    exp_q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    longint cyc = 0;
    int     done_cnt = 0;
    int     both_hi = 0;
    int     ready_zwr = 0;
    int     wr_unbusy = 0;
    logic   busy_at_done = 1'b0;
    longint done_cyc = 0;

    // Observe outputs just after each rising edge, so tasks working on the falling edge see settled values.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            if (wr_en && zwr_en) both_hi++;
            if (zwr_en && in_ready) ready_zwr++;
            if ((wr_en || zwr_en) && !busy) wr_unbusy++;
            if (wr_en || zwr_en)
                obs.push_back('{z: zwr_en, f: filter_id, a: out_addr, v: out_val, cyc: cyc});
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
    end

    function automatic bq_t bytes_of(input logic [63:0] v, input int n);
        bq_t r;
        for (int i = n - 1; i >= 0; i--) r.push_back(v[8*i +: 8]);
        return r;
    endfunction

    function automatic bq_t seal(input bq_t c);
        bq_t r;
        r = c;
`ifdef LOADER_CKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 1; i < c.size(); i++) x ^= c[i];
            r.push_back(x);
        end
`endif
        return r;
    endfunction

    // Reference: list of writes a command must produce, plus whether it must raise cmd_err.
    function automatic logic model(input bq_t c);
        logic        err;
        int          f;
        int          a;
        logic [31:0] v;
        err = 1'b0;
        exp_q.delete();
        f = (c.size() > 1) ? int'(c[1]) : 0;
        case (c[0])
            8'h01:
                for (int fi = 0; fi < 16; fi++)
                    for (int ai = 0; ai < 512; ai++)
                        exp_q.push_back('{1'b1, 4'(fi), 9'(ai), 32'h0, 0});
            8'h02:
                if (f > 15) err = 1'b1;
                else for (int ai = 0; ai < 512; ai++) exp_q.push_back('{1'b1, 4'(f), 9'(ai), 32'h0, 0});
            8'h03:
                if (f > 15) err = 1'b1;
                else for (int k = 0; k < 512; k++) begin
                    v = 32'h0;
                    for (int j = 0; j < 4; j++) v = v + (32'(c[2 + 4*k + j]) << (8*j));
                    exp_q.push_back('{1'b0, 4'(f), 9'(k), v, 0});
                end
            8'h04: begin
                a = (int'(c[2]) % 2) * 256 + int'(c[3]);
                v = 32'h0;
                for (int j = 0; j < 4; j++) v = v + (32'(c[4 + j]) << (8*j));
                if (f > 15) err = 1'b1;
                else exp_q.push_back('{1'b0, 4'(f), 9'(a), v, 0});
            end
            default: err = 1'b1;
        endcase
`ifdef LOADER_CKSUM_EN
        if (c[0] == 8'h03 || c[0] == 8'h04) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 1; i < c.size() - 1; i++) x ^= c[i];
            if (x != c[c.size() - 1]) err = 1'b1;
        end
`endif
        return err;
    endfunction

    // 0 = observed writes equal the model, 1 = count differs, 2 = content differs
    function automatic int ev_score();
        if (obs.size() != exp_q.size()) return 1;
        foreach (obs[i])
            if (obs[i].z !== exp_q[i].z || obs[i].f !== exp_q[i].f || obs[i].a !== exp_q[i].a ||
                (!exp_q[i].z && obs[i].v !== exp_q[i].v)) return 2;
        return 0;
    endfunction

    function automatic logic sweep_contiguous();
        if (obs.size() == 0) return 1'b0;
        return (obs[obs.size()-1].cyc - obs[0].cyc) == longint'(obs.size() - 1);
    endfunction

    task automatic clear_obs();
        obs.delete();
        done_cnt     = 0;
        ready_zwr    = 0;
        wr_unbusy    = 0;
        busy_at_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic acc;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        do begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 20000);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_byte: byte %02h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic send_cmd(input bq_t c, input logic gaps);
        foreach (c[i]) send_byte(c[i], (gaps && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done: no done pulse within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({in_ready, wr_en, zwr_en, out_val, out_addr, filter_id, busy, done, cmd_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b zwr=%b val=%h addr=%h fid=%h busy=%b done=%b err=%b, want all 0",
                     in_ready, wr_en, zwr_en, out_val, out_addr, filter_id, busy, done, cmd_err);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_held: in_ready=%b want 0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_clear_all();
        bq_t  c;
        logic e;
        c.push_back(8'h01);
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(9000);
        n_tests++;
        if (ev_score() !== 0) begin
            n_fail++; $display("FAIL clear_all_writes: score=%0d got %0d writes want %0d", ev_score(), obs.size(), exp_q.size());
        end
        n_tests++;
        if (!sweep_contiguous()) begin
            n_fail++; $display("FAIL clear_all_contiguous: zero writes not in consecutive cycles");
        end
        n_tests++;
        if (ready_zwr !== 0 || wr_unbusy !== 0) begin
            n_fail++; $display("FAIL clear_all_flags: ready_during_sweep=%0d unbusy_writes=%0d want 0 0", ready_zwr, wr_unbusy);
        end
        n_tests++;
        if (busy_at_done !== 1'b1 || cmd_err !== e) begin
            n_fail++; $display("FAIL clear_all_done: busy_at_done=%b cmd_err=%b want 1 %b", busy_at_done, cmd_err, e);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_all_after: busy=%b done=%b in_ready=%b want 0 0 1", busy, done, in_ready);
        end
    endtask

    task automatic test_poke();
        bq_t  c;
        logic e;
        c = seal(bytes_of(64'h04_03_01_2A_EF_BE_AD_DE, 8));
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(50);
        n_tests++;
        if (obs.size() != 1 || obs[0].z !== 1'b0 || obs[0].f !== 4'h3 || obs[0].a !== 9'h12A || obs[0].v !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL poke_directed: got %0d writes, first fid=%h addr=%h val=%h, want 1 write 3/12A/DEADBEEF",
                               obs.size(), obs.size() > 0 ? obs[0].f : 4'h0, obs.size() > 0 ? obs[0].a : 9'h0,
                               obs.size() > 0 ? obs[0].v : 32'h0);
        end
`ifndef LOADER_CKSUM_EN
        n_tests++;
        if (obs.size() != 1 || done_cyc != obs[0].cyc + 1) begin
            n_fail++; $display("FAIL poke_done_timing: done at cycle %0d, want write cycle + 1", done_cyc);
        end
`endif
        n_tests++;
        if (cmd_err !== e || done_cnt != 1) begin
            n_fail++; $display("FAIL poke_status: cmd_err=%b done_cnt=%0d want %b 1", cmd_err, done_cnt, e);
        end
        @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            c.delete();
            c.push_back(8'h04);
            c.push_back(8'($urandom_range(0, 15)));
            c.push_back(8'($urandom_range(0, 255)));
            for (int j = 0; j < 5; j++) c.push_back(8'($urandom));
            c = seal(c);
            e = model(c);
            clear_obs();
            send_cmd(c, 1'b1);
            wait_done(50);
            n_tests++;
            if (ev_score() !== 0 || cmd_err !== e) begin
                n_fail++; $display("FAIL poke_random[%0d]: score=%0d cmd_err=%b want 0 %b", t, ev_score(), cmd_err, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        bq_t  c;
        logic e;
        logic [31:0] w;
        c.push_back(8'h03);
        c.push_back(8'h0F);
        for (int k = 0; k < 512; k++) begin
            w = 32'(k);
            for (int j = 0; j < 4; j++) c.push_back(w[8*j +: 8]);
        end
        c = seal(c);
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(100);
        n_tests++;
        if (ev_score() !== 0) begin
            n_fail++; $display("FAIL load_directed: score=%0d got %0d writes want 512", ev_score(), obs.size());
        end
`ifndef LOADER_CKSUM_EN
        n_tests++;
        if (obs.size() == 0 || done_cyc != obs[obs.size()-1].cyc + 1) begin
            n_fail++; $display("FAIL load_done_timing: done at cycle %0d, want last write cycle + 1", done_cyc);
        end
`endif
        n_tests++;
        if (cmd_err !== e || wr_unbusy !== 0) begin
            n_fail++; $display("FAIL load_status: cmd_err=%b unbusy_writes=%0d want %b 0", cmd_err, wr_unbusy, e);
        end
        @(negedge clk);
        c.delete();
        c.push_back(8'h03);
        c.push_back(8'($urandom_range(0, 15)));
        for (int i = 0; i < 2048; i++) c.push_back(8'($urandom));
        c = seal(c);
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b1);
        wait_done(100);
        n_tests++;
        if (ev_score() !== 0 || cmd_err !== e) begin
            n_fail++; $display("FAIL load_random_gaps: score=%0d got %0d writes, cmd_err=%b want 0 512 %b",
                               ev_score(), obs.size(), cmd_err, e);
        end
        @(negedge clk);
    endtask

    task automatic test_unknown_opcode();
        bq_t  c;
        logic e;
        logic [7:0] ops[3];
        ops[0] = 8'h7F;
        ops[1] = 8'h00;
        ops[2] = 8'($urandom_range(5, 255));
        foreach (ops[i]) begin
            clear_obs();
            send_byte(ops[i], 0);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            n_tests++;
            if (cmd_err !== 1'b1 || busy !== 1'b0 || done_cnt != 0 || obs.size() != 0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL unknown_op_%02h: cmd_err=%b busy=%b done_cnt=%0d writes=%0d ready=%b want 1 0 0 0 1",
                                   ops[i], cmd_err, busy, done_cnt, obs.size(), in_ready);
            end
        end
        c = bytes_of(64'h02_05, 2);
        e = model(c);
        clear_obs();
        send_byte(c[0], 0);
        n_tests++;
        if (cmd_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL opcode_clears_err: cmd_err=%b busy=%b want 0 1", cmd_err, busy);
        end
        send_byte(c[1], 0);
        in_valid = 1'b0;
        wait_done(700);
        n_tests++;
        if (ev_score() !== 0 || !sweep_contiguous() || ready_zwr != 0 || cmd_err !== e) begin
            n_fail++; $display("FAIL clear_one: score=%0d writes=%0d ready_during_sweep=%0d cmd_err=%b want 0 512 0 %b",
                               ev_score(), obs.size(), ready_zwr, cmd_err, e);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_filter();
        bq_t  c;
        logic e;
        c = seal(bytes_of(64'h04_10_00_00_11_22_33_44, 8));
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(50);
        n_tests++;
        if (obs.size() != 0 || cmd_err !== 1'b1 || done_cnt != 1) begin
            n_fail++; $display("FAIL bad_filter_poke: writes=%0d cmd_err=%b done_cnt=%0d want 0 1 1", obs.size(), cmd_err, done_cnt);
        end
        @(negedge clk);
        c = seal(bytes_of(64'h04_07_01_FF_78_56_34_12, 8));
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(50);
        n_tests++;
        if (ev_score() !== 0 || cmd_err !== e) begin
            n_fail++; $display("FAIL after_bad_filter: score=%0d cmd_err=%b want 0 %b", ev_score(), cmd_err, e);
        end
        @(negedge clk);
        c = bytes_of(64'h02_F3, 2);
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(20);
        n_tests++;
        if (obs.size() != 0 || cmd_err !== e || done_cnt != 1) begin
            n_fail++; $display("FAIL bad_filter_clear: writes=%0d cmd_err=%b done_cnt=%0d want 0 %b 1", obs.size(), cmd_err, done_cnt, e);
        end
        @(negedge clk);
        c.delete();
        c.push_back(8'h03);
        c.push_back(8'($urandom_range(16, 255)));
        for (int i = 0; i < 2048; i++) c.push_back(8'($urandom));
        c = seal(c);
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(50);
        n_tests++;
        if (obs.size() != 0 || cmd_err !== e || done_cnt != 1) begin
            n_fail++; $display("FAIL bad_filter_load: writes=%0d cmd_err=%b done_cnt=%0d want 0 %b 1", obs.size(), cmd_err, done_cnt, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        bq_t  c;
        logic e;
        int   n;
        c.push_back(8'h01);
        clear_obs();
        send_cmd(c, 1'b0);
        n = 0;
        while (!(zwr_en && out_addr == 9'd100) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!(zwr_en && out_addr == 9'd100)) begin
            n_fail++; $display("FAIL reset_mid_reach: sweep never reached addr 100, addr=%h zwr=%b", out_addr, zwr_en);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (zwr_en !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_drop: zwr=%b busy=%b wr=%b ready=%b want 0 0 0 0", zwr_en, busy, wr_en, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || zwr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_release: ready=%b busy=%b zwr=%b want 1 0 0", in_ready, busy, zwr_en);
        end
        c = seal(bytes_of(64'h04_09_00_05_01_02_03_04, 8));
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(50);
        n_tests++;
        if (ev_score() !== 0 || cmd_err !== e) begin
            n_fail++; $display("FAIL reset_mid_resume: score=%0d cmd_err=%b want 0 %b", ev_score(), cmd_err, e);
        end
        @(negedge clk);
    endtask

`ifdef LOADER_CKSUM_EN
    task automatic test_cksum();
        bq_t  c;
        logic e;
        c = bytes_of(64'h04_01_00_10_11_22_33_44, 8);
        c.push_back(8'h00);
        e = model(c);
        clear_obs();
        send_cmd(c, 1'b0);
        wait_done(50);
        n_tests++;
        if (ev_score() !== 0 || obs.size() != 1 || cmd_err !== e || done_cnt != 1) begin
            n_fail++; $display("FAIL cksum_mismatch: score=%0d writes=%0d cmd_err=%b done_cnt=%0d want 0 1 %b 1",
                               ev_score(), obs.size(), cmd_err, e, done_cnt);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_exclusive();
        n_tests++;
        if (both_hi !== 0) begin
            n_fail++; $display("FAIL wr_zwr_exclusive: %0d cycles with both strobes high, want 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_clear_all();
        test_poke();
        test_load();
        test_unknown_opcode();
        test_bad_filter();
        test_reset_mid_sweep();
`ifdef LOADER_CKSUM_EN
        test_cksum();
`endif
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
